// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for an 8-digit common-cathode
// seven-segment array. Each digit owns a fixed slot of SCAN_DIV cycles that
// opens with BLANK_CYC blank cycles; masked digits stay dark but still use
// their slot, so the frame period does not depend on the mask.
module seg_scan_mux #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [63:0] seg_bus,
    input  logic [7:0]  digit_en,
    output logic [7:0]  array_seg,
    output logic [7:0]  array_com,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned SEG_W = 8;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);
    localparam logic [SEG_W-1:0] COM_OFF   = SEG_W'(8'hFF);
    localparam logic [SEG_W-1:0] SEG_OFF   = SEG_W'(8'h00);

    // Slot phase, decoded from the position inside the slot.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [SEG_W-1:0] seg_hold;
    logic             en_hold;

    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [SEG_W-1:0] seg_hold_nxt;
    logic             en_hold_nxt;
    logic [SEG_W-1:0] seg_nxt;
    logic [SEG_W-1:0] com_nxt;
    logic             tick_nxt;
    phase_t           phase_c;

    // Next-state and output decode from the current (cnt, idx, snapshot).
    always_comb begin
        cnt_nxt      = cnt + CNT_W'(1);
        idx_nxt      = idx;
        seg_hold_nxt = seg_hold;
        en_hold_nxt  = en_hold;
        seg_nxt      = SEG_OFF;
        com_nxt      = COM_OFF;
        tick_nxt     = 1'b0;
        phase_c      = (cnt < CNT_BLANK) ? PH_BLANK : PH_SHOW;

        // Slot wrap advances the digit; idx wraps 7 -> 0 naturally.
        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
                tick_nxt = 1'b1;
            end
        end

        // Snapshot the digit at slot start so mid-slot input changes are ignored.
        if (cnt == '0) begin
            seg_hold_nxt = seg_bus[{idx, 3'b000} +: SEG_W];
            en_hold_nxt  = digit_en[idx];
        end

        // Only a SHOW cycle of an enabled digit drives a common low.
        if (phase_c == PH_SHOW && en_hold) begin
            seg_nxt = seg_hold;
            com_nxt = ~(SEG_W'(1) << idx);
        end
    end

    // State and registered outputs; reset blanks the array immediately.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            seg_hold   <= '0;
            en_hold    <= 1'b0;
            array_seg  <= SEG_OFF;
            array_com  <= COM_OFF;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            seg_hold   <= seg_hold_nxt;
            en_hold    <= en_hold_nxt;
            array_seg  <= seg_nxt;
            array_com  <= com_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux: a small-divider instance checked against a
// cycle-count reference model, plus a default-size instance for slot and
// frame timing.
module tb_seg_scan_mux;

    localparam int unsigned SD  = 8;
    localparam int unsigned BC  = 2;
    localparam int unsigned SD2 = 1000;
    localparam int unsigned BC2 = 16;

    logic        clk_in;
    logic        rst;
    logic [63:0] seg_bus;
    logic [7:0]  digit_en;
    logic [7:0]  array_seg;
    logic [7:0]  array_com;
    logic        frame_tick;
    logic [7:0]  seg2;
    logic [7:0]  com2;
    logic        tick2;

    int checks;
    int errors;

    seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk_in(clk_in), .rst(rst), .seg_bus(seg_bus), .digit_en(digit_en),
        .array_seg(array_seg), .array_com(array_com), .frame_tick(frame_tick)
    );

    seg_scan_mux #(.SCAN_DIV(SD2), .BLANK_CYC(BC2)) dut_big (
        .clk_in(clk_in), .rst(rst), .seg_bus(seg_bus), .digit_en(digit_en),
        .array_seg(seg2), .array_com(com2), .frame_tick(tick2)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: position in the scan follows from the cycle count g
    // since reset; the digit pattern is whatever was on the inputs at slot start.
    int unsigned g;
    int unsigned m_c;
    int unsigned m_d;
    logic [7:0]  m_pat;
    logic        m_en;
    logic [7:0]  exp_seg;
    logic [7:0]  exp_com;
    logic        exp_tick;

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            g        <= 0;
            m_pat    <= 8'h00;
            m_en     <= 1'b0;
            exp_seg  <= 8'h00;
            exp_com  <= 8'hFF;
            exp_tick <= 1'b0;
        end else begin
            m_c = g % SD;
            m_d = (g / SD) % 8;
            if (m_c >= BC && m_en) begin
                exp_seg <= m_pat;
                exp_com <= ~(8'd1 << m_d);
            end else begin
                exp_seg <= 8'h00;
                exp_com <= 8'hFF;
            end
            exp_tick <= ((g % (8 * SD)) == (8 * SD - 1));
            if (m_c == 0) begin
                m_pat <= seg_bus[m_d * 8 +: 8];
                m_en  <= digit_en[m_d];
            end
            g <= g + 1;
        end
    end

    // Pulse reset mid-cycle; edge 1 is the first rising edge after release.
    task automatic do_reset();
        @(posedge clk_in);
        #2 rst = 1'b1;
        @(posedge clk_in);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        seg_bus  = 64'h0706050403020100;
        digit_en = 8'hFF;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (array_com !== 8'hFF || array_seg !== 8'h00 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: com=%h seg=%h tick=%b, required com=ff seg=00 tick=0",
                     array_com, array_seg, frame_tick);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int ticks;
        int multi;
        ticks = 0;
        multi = 0;
        seg_bus  = 64'h0706050403020100;
        digit_en = 8'hFF;
        do_reset();
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (array_com !== exp_com || array_seg !== exp_seg || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL scan_model edge %0d: com=%h seg=%h tick=%b, required com=%h seg=%h tick=%b",
                         e, array_com, array_seg, frame_tick, exp_com, exp_seg, exp_tick);
            end
            if ($countones(~array_com) > 1) multi++;
            if (frame_tick === 1'b1) ticks++;
            if (e == 2 || e == 3 || e == 11 || e == 59) begin
                checks++;
                if ((e == 2  && (array_com !== 8'hFF || array_seg !== 8'h00)) ||
                    (e == 3  && (array_com !== 8'hFE || array_seg !== 8'h00)) ||
                    (e == 11 && (array_com !== 8'hFD || array_seg !== 8'h01)) ||
                    (e == 59 && (array_com !== 8'h7F || array_seg !== 8'h07))) begin
                    errors++;
                    $display("FAIL scan_directed edge %0d: com=%h seg=%h", e, array_com, array_seg);
                end
            end
            if (e == 64 || e == 128) begin
                checks++;
                if (frame_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_tick edge %0d: got %b, required 1", e, frame_tick);
                end
            end
        end
        checks++;
        if (ticks != 3) begin
            errors++;
            $display("FAIL tick_count: got %0d pulses in 200 edges, required 3", ticks);
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL one_common: %0d cycles had several commons low, required 0", multi);
        end
    endtask

    task automatic test_mask();
        seg_bus  = 64'h0706050403020100;
        digit_en = 8'b1111_1101;
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (array_com !== exp_com || array_seg !== exp_seg || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL mask_model edge %0d: com=%h seg=%h tick=%b, required com=%h seg=%h tick=%b",
                         e, array_com, array_seg, frame_tick, exp_com, exp_seg, exp_tick);
            end
            if ((e >= 9 && e <= 16) || (e >= 19 && e <= 24) || e == 64) begin
                checks++;
                if (((e >= 9 && e <= 16) && (array_com !== 8'hFF || array_seg !== 8'h00)) ||
                    ((e >= 19 && e <= 24) && (array_com !== 8'hFB || array_seg !== 8'h02)) ||
                    (e == 64 && frame_tick !== 1'b1)) begin
                    errors++;
                    $display("FAIL mask_directed edge %0d: com=%h seg=%h tick=%b",
                             e, array_com, array_seg, frame_tick);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        seg_bus  = 64'h070605040302013F;
        digit_en = 8'hFF;
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (array_com !== exp_com || array_seg !== exp_seg) begin
                errors++;
                $display("FAIL snap_model edge %0d: com=%h seg=%h, required com=%h seg=%h",
                         e, array_com, array_seg, exp_com, exp_seg);
            end
            if ((e >= 4 && e <= 8) || (e >= 67 && e <= 72)) begin
                checks++;
                if (array_seg !== ((e <= 8) ? 8'h3F : 8'h06)) begin
                    errors++;
                    $display("FAIL snap_hold edge %0d: seg=%h, required %h",
                             e, array_seg, (e <= 8) ? 8'h3F : 8'h06);
                end
            end
            if (e == 3) seg_bus[7:0] = 8'h06;
        end
    endtask

    task automatic test_random();
        seg_bus  = {$urandom, $urandom};
        digit_en = 8'($urandom);
        do_reset();
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (array_com !== exp_com || array_seg !== exp_seg || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL random_model edge %0d: com=%h seg=%h tick=%b, required com=%h seg=%h tick=%b",
                         e, array_com, array_seg, frame_tick, exp_com, exp_seg, exp_tick);
            end
            if ($urandom_range(0, 5) == 0) seg_bus = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) digit_en = 8'($urandom);
        end
        digit_en = 8'h00;
        do_reset();
        for (int e = 1; e <= 140; e++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (array_com !== 8'hFF || frame_tick !== ((e % 64) == 0)) begin
                errors++;
                $display("FAIL all_masked edge %0d: com=%h tick=%b", e, array_com, frame_tick);
            end
        end
    endtask

    task automatic test_async_reset();
        seg_bus  = 64'h0706050403020100;
        digit_en = 8'hFF;
        do_reset();
        repeat (20) @(posedge clk_in);
        #1;
        checks++;
        if (array_com !== 8'hFB || array_seg !== 8'h02) begin
            errors++;
            $display("FAIL pre_reset edge 20: com=%h seg=%h, required com=fb seg=02", array_com, array_seg);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (array_com !== 8'hFF || array_seg !== 8'h00 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: com=%h seg=%h tick=%b, required com=ff seg=00 tick=0",
                     array_com, array_seg, frame_tick);
        end
        @(posedge clk_in);
        #1 rst = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (array_com !== exp_com || array_seg !== exp_seg ||
                (e <= 2 && array_com !== 8'hFF) || (e >= 3 && e <= 8 && array_com !== 8'hFE)) begin
                errors++;
                $display("FAIL restart edge %0d: com=%h seg=%h, required com=%h seg=%h",
                         e, array_com, array_seg, exp_com, exp_seg);
            end
        end
    endtask

    task automatic test_long_div();
        int on_cnt [8];
        int tick_at [$];
        for (int d = 0; d < 8; d++) on_cnt[d] = 0;
        seg_bus  = 64'h8877665544332211;
        digit_en = 8'hFF;
        do_reset();
        for (int e = 1; e <= 16010; e++) begin
            @(posedge clk_in);
            #1;
            if (e <= 8000) begin
                for (int d = 0; d < 8; d++) begin
                    if (com2 === ~(8'd1 << d)) on_cnt[d]++;
                end
            end
            if (tick2 === 1'b1) tick_at.push_back(e);
            if (e == 500) begin
                checks++;
                if (com2 !== 8'hFE || seg2 !== 8'h11) begin
                    errors++;
                    $display("FAIL big_show edge 500: com=%h seg=%h, required com=fe seg=11", com2, seg2);
                end
            end
        end
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (on_cnt[d] != 984) begin
                errors++;
                $display("FAIL big_on_time digit %0d: %0d cycles, required 984", d, on_cnt[d]);
            end
        end
        checks++;
        if (tick_at.size() != 2 || tick_at[0] != 8000 || tick_at[1] - tick_at[0] != 8000) begin
            errors++;
            $display("FAIL big_frame_tick: %0d pulses, first at %0d, required pulses at 8000 and 16000",
                     tick_at.size(), (tick_at.size() > 0) ? tick_at[0] : -1);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        seg_bus  = '0;
        digit_en = '0;
        test_reset();
        test_scan();
        test_mask();
        test_snapshot();
        test_random();
        test_async_reset();
        test_long_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
